simplerisc_execute_unit: RTL and testbench
==========================================

Name: simplerisc_execute_unit

Overview:
- Execute (EX) stage of the 5-stage SimpleRisc pipeline, bundled with instruction decode and the EX/MA pipeline register.
- Decodes the EX-stage instruction into a 22-bit control bus.
- Computes the immediate, runs the ALU, holds the E/GT flags, and resolves branches (predict not-taken; the taken result goes back to IF).
- Registers PC, ALU result, store operand, IR and control bus into the MA stage.

Parameters:
- none (ISA widths fixed: 32-bit data/PC/IR, 22-bit control bus)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ex_valid  input  1  EX slot holds a real instruction (0 = bubble)
- ex_pc  input  32  PC of EX instruction
- ex_ir  input  32  EX instruction word
- ex_op_a  input  32  rs1 value (ra value for ret), already forwarded
- ex_op_b  input  32  rs2 value, already forwarded
- ex_op_st  input  32  rd value, used as store data
- ex_ctrl  output  22  decoded control bus (combinational)
- alu_result  output  32  ALU result (combinational)
- branch_taken  output  1  redirect fetch (combinational)
- branch_pc  output  32  redirect target (combinational)
- ma_valid  output  1  registered ex_valid
- ma_pc  output  32  registered PC
- ma_alu_result  output  32  registered ALU result
- ma_op2  output  32  registered store data
- ma_ir  output  32  registered IR
- ma_ctrl  output  22  registered control bus

Behaviour:
Instruction field decode:
- opcode = ir[31:27]; I = ir[26]; rd = ir[25:22]; rs1 = ir[21:18]; rs2 = ir[17:14]; modifier = ir[17:16]; imm16 = ir[15:0]; offset27 = ir[26:0].

Opcodes:
- 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or
- 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr, 13 nop
- 14 ld, 15 st, 16 beq, 17 bgt, 18 b, 19 call, 20 ret
- 21-31 decode as nop (all-zero control bus).

Control bus bits:
- [0] isSt, [1] isLd, [2] isBeq, [3] isBgt, [4] isRet, [5] isImmediate, [6] isWb, [7] isUBranch, [8] isCall
- [9] add, [10] sub, [11] mul, [12] div, [13] mod, [14] cmp, [15] and, [16] or, [17] not, [18] mov, [19] lsl, [20] lsr, [21] asr

Control bus rules:
- add bit is also set for ld and st.
- isImmediate = I for opcodes 0-12; always 1 for ld and st.
- isWb is set for opcodes 0-4, 6-12, ld and call; clear for all others.
- isUBranch is set for b, call and ret.
- When ex_valid=0, ex_ctrl = 0.

Immediate (immx):
- modifier 00 or 11: sign-extend imm16.
- modifier 01: zero-extend imm16.
- modifier 10: imm16 << 16.

ALU:
- A = ex_op_a; B = isImmediate ? immx : ex_op_b.
- All arithmetic is 32-bit, wrap-around.
- mul keeps the low 32 bits.
- div/mod are signed, truncating toward zero. B = 0 gives div → 0, mod → A.
- not → ~B; mov → B.
- Shifts use B[4:0]; asr is arithmetic.
- cmp result = A − B, which is not written back.
- No ALU bit set → result 0.

Flags:
- Two registered flags, E and GT.
- Updated on the clock edge only by a valid cmp: E = (A==B), GT = signed(A) > signed(B).
- Otherwise the flags hold their value.
- A beq/bgt in the cycle after a cmp sees the updated flags.

Branch resolution:
- branch_taken = ex_valid & (isUBranch | isBeq&E | isBgt&GT).
- branch_pc = isRet ? A : ex_pc + (sign-extended offset27 << 2).
- branch_pc is computed even when branch_taken=0.

EX/MA latch:
- Every rising edge: ma_* ← ex_valid, ex_pc, alu_result, ex_op_st, ex_ir, ex_ctrl.
- No stall or enable; bubbles are inserted upstream via ex_valid.

Reset:
- While reset=0, all ma_* outputs and E/GT are 0, immediately (asynchronous).
- Reset asserted mid-operation discards the in-flight instruction.

Optional Feature:
- Macro: SRISC_DIV_EN.
- Defined: div and mod are implemented as specified above.
- Not defined: no divider is built; div and mod yield alu_result = 0. Their control bits are still decoded and isWb is still set.

Test Plan:
- Reset: reset=0 → all ma_* = 0 and E=GT=0. Release reset, apply nop → ma_ctrl = 0.
- ALU: add r1,r2,r3 with A=5, B=7 → alu_result=12, ex_ctrl[9]=1, ex_ctrl[6]=1. Next edge → ma_alu_result=12.
- Immediate modifiers: imm16=0x8000 with modifiers 00 / 01 / 10 and mov → B = 0xFFFF8000 / 0x00008000 / 0x80000000 respectively.
- Compare and branch: cmp A=3, B=3, then beq offset=4 at PC=0x20 → branch_taken=1, branch_pc=0x30. Follow with bgt → branch_taken=0.
- Return and bubble: ret with A=0x100 → branch_taken=1, branch_pc=0x100. Same ret with ex_valid=0 → branch_taken=0 and ma_ctrl=0 after the edge.
- Division: div A=−7, B=2 → −3; mod → −1; div by 0 → 0. Without SRISC_DIV_EN both div and mod give 0.

Source files
------------

// File: rtl/simplerisc_execute_unit_if.sv
// rtl/simplerisc_execute_unit_if.sv - EX-stage operand/result bundle for simplerisc_execute_unit
interface simplerisc_execute_unit_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_ir;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic [31:0] ex_op_st;
  logic [21:0] ex_ctrl;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        ma_valid;
  logic [31:0] ma_pc;
  logic [31:0] ma_alu_result;
  logic [31:0] ma_op2;
  logic [31:0] ma_ir;
  logic [21:0] ma_ctrl;

  modport master (
    output ex_valid, ex_pc, ex_ir, ex_op_a, ex_op_b, ex_op_st,
    input  ex_ctrl, alu_result, branch_taken, branch_pc,
    input  ma_valid, ma_pc, ma_alu_result, ma_op2, ma_ir, ma_ctrl
  );

  modport slave (
    input  ex_valid, ex_pc, ex_ir, ex_op_a, ex_op_b, ex_op_st,
    output ex_ctrl, alu_result, branch_taken, branch_pc,
    output ma_valid, ma_pc, ma_alu_result, ma_op2, ma_ir, ma_ctrl
  );
endinterface

// File: rtl/simplerisc_execute_unit.sv
// rtl/simplerisc_execute_unit.sv - SimpleRisc EX stage: decode, ALU, flags, branch resolve, EX/MA latch
// Optional signed divider/modulo enabled by defining SRISC_DIV_EN.
module simplerisc_execute_unit (
  input logic                      clk,
  input logic                      reset,
  simplerisc_execute_unit_if.slave bus
);
  localparam logic [4:0] OP_CMP = 5'd5,  OP_ALU_LAST = 5'd12;
  localparam logic [4:0] OP_LD  = 5'd14, OP_ST  = 5'd15, OP_BEQ = 5'd16;
  localparam logic [4:0] OP_BGT = 5'd17, OP_B   = 5'd18, OP_CALL = 5'd19, OP_RET = 5'd20;
  localparam int C_ST = 0, C_LD = 1, C_BEQ = 2, C_BGT = 3, C_RET = 4, C_IMM = 5;
  localparam int C_WB = 6, C_UBR = 7, C_CALL = 8, C_ADD = 9, C_SUB = 10, C_MUL = 11;
  localparam int C_DIV = 12, C_MOD = 13, C_CMP = 14, C_AND = 15, C_OR = 16, C_NOT = 17;
  localparam int C_MOV = 18, C_LSL = 19, C_LSR = 20, C_ASR = 21;

  logic [4:0]  opcode;
  logic [21:0] ctrl;
  logic [31:0] op_a, op_b, immx, quo, rem, result, br_offset;
  logic [4:0]  shamt;
  logic        e_q, e_d, gt_q, gt_d;
  logic        ma_valid_q, ma_valid_d;
  logic [31:0] ma_pc_q, ma_pc_d, ma_alu_result_q, ma_alu_result_d;
  logic [31:0] ma_op2_q, ma_op2_d, ma_ir_q, ma_ir_d;
  logic [21:0] ma_ctrl_q, ma_ctrl_d;

  assign opcode = bus.ex_ir[31:27];
  assign op_a   = bus.ex_op_a;

  // ALU opcodes 0..12 map one-to-one onto control bits 9..21
  always_comb begin
    ctrl = '0;
    if (opcode <= OP_ALU_LAST) begin
      ctrl[5'd9 + opcode] = 1'b1;
      ctrl[C_IMM]         = bus.ex_ir[26];
      ctrl[C_WB]          = (opcode != OP_CMP);
    end else begin
      case (opcode)
        OP_LD:   begin ctrl[C_LD] = 1'b1; ctrl[C_ADD] = 1'b1; ctrl[C_IMM] = 1'b1; ctrl[C_WB] = 1'b1; end
        OP_ST:   begin ctrl[C_ST] = 1'b1; ctrl[C_ADD] = 1'b1; ctrl[C_IMM] = 1'b1; end
        OP_BEQ:  ctrl[C_BEQ] = 1'b1;
        OP_BGT:  ctrl[C_BGT] = 1'b1;
        OP_B:    ctrl[C_UBR] = 1'b1;
        OP_CALL: begin ctrl[C_CALL] = 1'b1; ctrl[C_UBR] = 1'b1; ctrl[C_WB] = 1'b1; end
        OP_RET:  begin ctrl[C_RET] = 1'b1; ctrl[C_UBR] = 1'b1; end
        default: ctrl = '0;
      endcase
    end
    if (!bus.ex_valid) ctrl = '0;
  end

  always_comb begin
    case (bus.ex_ir[17:16])
      2'b01:   immx = {16'h0000, bus.ex_ir[15:0]};
      2'b10:   immx = {bus.ex_ir[15:0], 16'h0000};
      default: immx = {{16{bus.ex_ir[15]}}, bus.ex_ir[15:0]};
    endcase
  end

  assign op_b  = ctrl[C_IMM] ? immx : bus.ex_op_b;
  assign shamt = op_b[4:0];

`ifdef SRISC_DIV_EN
  // Divide by zero is defined as quotient 0, remainder A
  always_comb begin
    quo = '0;
    rem = op_a;
    if (op_b != '0) begin
      quo = $signed(op_a) / $signed(op_b);
      rem = $signed(op_a) % $signed(op_b);
    end
  end
`else
  assign quo = '0;
  assign rem = '0;
`endif

  always_comb begin
    result = '0;
    if (ctrl[C_ADD])                     result = op_a + op_b;
    else if (ctrl[C_SUB] || ctrl[C_CMP]) result = op_a - op_b;
    else if (ctrl[C_MUL])                result = op_a * op_b;
    else if (ctrl[C_DIV])                result = quo;
    else if (ctrl[C_MOD])                result = rem;
    else if (ctrl[C_AND])                result = op_a & op_b;
    else if (ctrl[C_OR])                 result = op_a | op_b;
    else if (ctrl[C_NOT])                result = ~op_b;
    else if (ctrl[C_MOV])                result = op_b;
    else if (ctrl[C_LSL])                result = op_a << shamt;
    else if (ctrl[C_LSR])                result = op_a >> shamt;
    else if (ctrl[C_ASR])                result = $signed(op_a) >>> shamt;
  end

  always_comb begin
    e_d  = e_q;
    gt_d = gt_q;
    if (ctrl[C_CMP]) begin
      e_d  = (op_a == op_b);
      gt_d = ($signed(op_a) > $signed(op_b));
    end
  end

  assign br_offset        = {{3{bus.ex_ir[26]}}, bus.ex_ir[26:0], 2'b00};
  assign bus.branch_pc    = ctrl[C_RET] ? op_a : bus.ex_pc + br_offset;
  assign bus.branch_taken = bus.ex_valid &
                            (ctrl[C_UBR] | (ctrl[C_BEQ] & e_q) | (ctrl[C_BGT] & gt_q));
  assign bus.ex_ctrl      = ctrl;
  assign bus.alu_result   = result;

  always_comb begin
    ma_valid_d      = bus.ex_valid;
    ma_pc_d         = bus.ex_pc;
    ma_alu_result_d = result;
    ma_op2_d        = bus.ex_op_st;
    ma_ir_d         = bus.ex_ir;
    ma_ctrl_d       = ctrl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q             <= 1'b0;
      gt_q            <= 1'b0;
      ma_valid_q      <= 1'b0;
      ma_pc_q         <= '0;
      ma_alu_result_q <= '0;
      ma_op2_q        <= '0;
      ma_ir_q         <= '0;
      ma_ctrl_q       <= '0;
    end else begin
      e_q             <= e_d;
      gt_q            <= gt_d;
      ma_valid_q      <= ma_valid_d;
      ma_pc_q         <= ma_pc_d;
      ma_alu_result_q <= ma_alu_result_d;
      ma_op2_q        <= ma_op2_d;
      ma_ir_q         <= ma_ir_d;
      ma_ctrl_q       <= ma_ctrl_d;
    end
  end

  assign bus.ma_valid      = ma_valid_q;
  assign bus.ma_pc         = ma_pc_q;
  assign bus.ma_alu_result = ma_alu_result_q;
  assign bus.ma_op2        = ma_op2_q;
  assign bus.ma_ir         = ma_ir_q;
  assign bus.ma_ctrl       = ma_ctrl_q;
endmodule

// File: tb/tb_simplerisc_execute_unit.sv
// tb/tb_simplerisc_execute_unit.sv - randomized self-checking bench for simplerisc_execute_unit
module tb_simplerisc_execute_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simplerisc_execute_unit_if bus ();
  simplerisc_execute_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int   n_checks = 0;
  int   n_pass   = 0;
  logic flag_e   = 1'b0;
  logic flag_gt  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(int op, int rd, int rs1, int rs2);
    return {5'(op), 1'b0, 4'(rd), 4'(rs1), 4'(rs2), 14'h0};
  endfunction

  function automatic logic [31:0] enc_i(int op, logic [1:0] md, logic [15:0] imm);
    return {5'(op), 1'b1, 4'd1, 4'd2, md, imm};
  endfunction

  function automatic logic [31:0] enc_br(int op, logic [26:0] off);
    return {5'(op), off};
  endfunction

  function automatic logic [21:0] model_ctrl(logic v, logic [31:0] ir);
    int op;
    logic [21:0] c;
    op = int'(ir[31:27]);
    c  = '0;
    if (!v) return c;
    if (op <= 12) begin
      c[9 + op] = 1'b1;
      c[5]      = ir[26];
      c[6]      = (op != 5);
    end
    case (op)
      14: begin c[1] = 1'b1; c[9] = 1'b1; c[5] = 1'b1; c[6] = 1'b1; end
      15: begin c[0] = 1'b1; c[9] = 1'b1; c[5] = 1'b1; end
      16: c[2] = 1'b1;
      17: c[3] = 1'b1;
      18: c[7] = 1'b1;
      19: begin c[8] = 1'b1; c[7] = 1'b1; c[6] = 1'b1; end
      20: begin c[4] = 1'b1; c[7] = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] model_b(logic [31:0] ir, logic [31:0] b);
    int op;
    logic [15:0] imm;
    op  = int'(ir[31:27]);
    imm = ir[15:0];
    if (!((op <= 12 && ir[26]) || op == 14 || op == 15)) return b;
    case (ir[17:16])
      2'b01:   return 32'(imm);
      2'b10:   return 32'(imm) * 32'd65536;
      default: return 32'(longint'($signed(imm)));
    endcase
  endfunction

  function automatic logic [31:0] model_alu(logic v, logic [31:0] ir, logic [31:0] a, logic [31:0] b);
    int op;
    logic [31:0] bb;
    longint sa, sb, q, m;
    op = int'(ir[31:27]);
    if (!v) return 32'h0;
    bb = model_b(ir, b);
    sa = longint'($signed(a));
    sb = longint'($signed(bb));
`ifdef SRISC_DIV_EN
    if (sb == 0) begin
      q = 0;
      m = sa;
    end else begin
      q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
      if ((sa < 0) != (sb < 0)) q = -q;
      m = sa - q * sb;
    end
`else
    q = 0;
    m = 0;
`endif
    case (op)
      0, 14, 15: return a + bb;
      1, 5:      return a - bb;
      2:         return 32'(sa * sb);
      3:         return 32'(q);
      4:         return 32'(m);
      6:         return a & bb;
      7:         return a | bb;
      8:         return ~bb;
      9:         return bb;
      10:        return a << bb[4:0];
      11:        return a >> bb[4:0];
      12:        return 32'(sa >>> bb[4:0]);
      default:   return 32'h0;
    endcase
  endfunction

  task automatic run(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ir,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
    logic [21:0] ec;
    logic [31:0] er, ebpc, bb;
    logic        et;
    int          op;
    op   = int'(ir[31:27]);
    ec   = model_ctrl(v, ir);
    er   = model_alu(v, ir, a, b);
    bb   = model_b(ir, b);
    et   = v && (op == 18 || op == 19 || op == 20 || (op == 16 && flag_e) || (op == 17 && flag_gt));
    ebpc = (op == 20) ? a : pc + 32'(longint'($signed(ir[26:0])) * 4);
    @(negedge clk);
    bus.ex_valid = v;
    bus.ex_pc    = pc;
    bus.ex_ir    = ir;
    bus.ex_op_a  = a;
    bus.ex_op_b  = b;
    bus.ex_op_st = st;
    #1;
    check({tag, ".ex_ctrl"}, 32'(bus.ex_ctrl), 32'(ec));
    check({tag, ".alu_result"}, bus.alu_result, er);
    check({tag, ".branch_taken"}, 32'(bus.branch_taken), 32'(et));
    if (v) check({tag, ".branch_pc"}, bus.branch_pc, ebpc);
    @(posedge clk);
    #1;
    check({tag, ".ma_valid"}, 32'(bus.ma_valid), 32'(v));
    check({tag, ".ma_pc"}, bus.ma_pc, pc);
    check({tag, ".ma_alu_result"}, bus.ma_alu_result, er);
    check({tag, ".ma_op2"}, bus.ma_op2, st);
    check({tag, ".ma_ir"}, bus.ma_ir, ir);
    check({tag, ".ma_ctrl"}, 32'(bus.ma_ctrl), 32'(ec));
    if (v && op == 5) begin
      flag_e  = (a == bb);
      flag_gt = ($signed(a) > $signed(bb));
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.ex_valid = 1'b1;
    bus.ex_pc    = 32'h40;
    bus.ex_ir    = enc_r(0, 1, 2, 3);
    bus.ex_op_a  = 32'd9;
    bus.ex_op_b  = 32'd9;
    bus.ex_op_st = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ma_valid", 32'(bus.ma_valid), 32'h0);
    check("rst.ma_pc", bus.ma_pc, 32'h0);
    check("rst.ma_alu_result", bus.ma_alu_result, 32'h0);
    check("rst.ma_op2", bus.ma_op2, 32'h0);
    check("rst.ma_ir", bus.ma_ir, 32'h0);
    check("rst.ma_ctrl", 32'(bus.ma_ctrl), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    run("nop", 1'b1, 32'h0, enc_r(13, 0, 0, 0), 32'h1, 32'h2, 32'h3);
    check("nop.lit_ma_ctrl", 32'(bus.ma_ctrl), 32'h0);
    run("bgt_after_rst", 1'b1, 32'h8, enc_br(17, 27'd2), 32'h0, 32'h0, 32'h0);
    check("bgt_after_rst.lit", 32'(bus.branch_taken), 32'h0);

    run("add", 1'b1, 32'h4, enc_r(0, 1, 2, 3), 32'd5, 32'd7, 32'h0);
    check("add.lit_ma_alu", bus.ma_alu_result, 32'd12);
    check("add.lit_ctrl", 32'(bus.ex_ctrl), 32'h000240);

    run("mov00", 1'b1, 32'h8, enc_i(9, 2'b00, 16'h8000), 32'h0, 32'h0, 32'h0);
    check("mov00.lit", bus.alu_result, 32'hFFFF8000);
    run("mov01", 1'b1, 32'hC, enc_i(9, 2'b01, 16'h8000), 32'h0, 32'h0, 32'h0);
    check("mov01.lit", bus.alu_result, 32'h00008000);
    run("mov10", 1'b1, 32'h10, enc_i(9, 2'b10, 16'h8000), 32'h0, 32'h0, 32'h0);
    check("mov10.lit", bus.alu_result, 32'h80000000);

    run("cmp", 1'b1, 32'h1C, enc_r(5, 0, 1, 2), 32'd3, 32'd3, 32'h0);
    run("beq", 1'b1, 32'h20, enc_br(16, 27'd4), 32'h0, 32'h0, 32'h0);
    check("beq.lit_taken", 32'(bus.branch_taken), 32'h1);
    check("beq.lit_pc", bus.branch_pc, 32'h30);
    run("bgt", 1'b1, 32'h24, enc_br(17, 27'd4), 32'h0, 32'h0, 32'h0);
    check("bgt.lit_taken", 32'(bus.branch_taken), 32'h0);

    run("ret", 1'b1, 32'h28, enc_r(20, 0, 15, 0), 32'h100, 32'h0, 32'h0);
    check("ret.lit_taken", 32'(bus.branch_taken), 32'h1);
    check("ret.lit_pc", bus.branch_pc, 32'h100);
    run("ret_bubble", 1'b0, 32'h28, enc_r(20, 0, 15, 0), 32'h100, 32'h0, 32'h0);
    check("ret_bubble.lit_taken", 32'(bus.branch_taken), 32'h0);
    check("ret_bubble.lit_ma_ctrl", 32'(bus.ma_ctrl), 32'h0);

    run("div", 1'b1, 32'h30, enc_r(3, 1, 2, 3), -32'sd7, 32'd2, 32'h0);
`ifdef SRISC_DIV_EN
    check("div.lit", bus.alu_result, -32'sd3);
`else
    check("div.lit", bus.alu_result, 32'h0);
`endif
    run("mod", 1'b1, 32'h34, enc_r(4, 1, 2, 3), -32'sd7, 32'd2, 32'h0);
`ifdef SRISC_DIV_EN
    check("mod.lit", bus.alu_result, -32'sd1);
`else
    check("mod.lit", bus.alu_result, 32'h0);
`endif
    run("div0", 1'b1, 32'h38, enc_r(3, 1, 2, 3), 32'd77, 32'd0, 32'h0);
    check("div0.lit", bus.alu_result, 32'h0);
    run("mod0", 1'b1, 32'h3C, enc_r(4, 1, 2, 3), 32'd77, 32'd0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ir, a, b;
      logic        v;
      ir = {5'($urandom_range(0, 31)), 27'($urandom)};
      v  = ($urandom_range(0, 7) != 0);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a = a & 32'h0000_001F;
        b = b & 32'h0000_001F;
      end
      if (a == 32'h8000_0000) a = 32'h8000_0001;
      run("rnd", v, $urandom & 32'hFFFF_FFFC, ir, a, b, $urandom);
    end

    run("cmp_pre_rst", 1'b1, 32'h50, enc_r(5, 0, 1, 2), 32'd9, 32'd9, 32'h0);
    run("add_pre_rst", 1'b1, 32'h54, enc_r(0, 1, 2, 3), 32'd1, 32'd2, 32'h77);
    #2;
    reset = 1'b0;
    #1;
    check("midrst.ma_valid", 32'(bus.ma_valid), 32'h0);
    check("midrst.ma_ir", bus.ma_ir, 32'h0);
    check("midrst.ma_alu_result", bus.ma_alu_result, 32'h0);
    check("midrst.ma_op2", bus.ma_op2, 32'h0);
    flag_e  = 1'b0;
    flag_gt = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run("beq_post_rst", 1'b1, 32'h60, enc_br(16, 27'd8), 32'h0, 32'h0, 32'h0);
    check("beq_post_rst.lit", 32'(bus.branch_taken), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
